// File: rtl/fb_scan_ctrl.sv
// BCM scan controller: fetches each {row,plane} word, shifts it out MSB first, latches, then dwells.
// Define ROW_BLANK_EN to insert an oe-off BLANK gap whenever the row advances.
module fb_scan_ctrl #(
  parameter int ROWS       = 16,
  parameter int PLANES     = 8,
  parameter int SCLK_HALF  = 1,
  parameter int DWELL_BASE = 32,
  parameter int BLANK_CYC  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [6:0]  rd_addr,
  input  logic [63:0] rd_data,
  output logic        sdo,
  output logic        sclk,
  output logic        slatch,
  output logic        oe_n,
  output logic [3:0]  row_sel,
  output logic        frame_sync
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;
  localparam logic [2:0] S_DWELL = 3'd5;
  localparam logic [2:0] S_NEXT  = 3'd6;
  localparam logic [2:0] S_BLANK = 3'd7;

  localparam int DWELL_MAX = DWELL_BASE << (PLANES - 1);
  localparam int CW = $clog2(((DWELL_MAX > BLANK_CYC) ? DWELL_MAX : BLANK_CYC) + 1);
  localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

  localparam logic [3:0]    ROW_LAST   = 4'(ROWS - 1);
  localparam logic [2:0]    PLANE_LAST = 3'(PLANES - 1);
  localparam logic [HW-1:0] HALF_LAST  = HW'(SCLK_HALF - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  logic [2:0]    state_q, state_d;
  logic [3:0]    row_q, row_d;
  logic [2:0]    plane_q, plane_d;
  logic [3:0]    row_sel_q, row_sel_d;
  logic [63:0]   shreg_q, shreg_d;
  logic [5:0]    bit_q, bit_d;
  logic [HW-1:0] half_q, half_d;
  logic          sclk_q, sclk_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [CW-1:0] dwell_last;
  logic          plane_wrap;

  assign dwell_last = (CW'(DWELL_BASE) << plane_q) - CW'(1);
  assign plane_wrap = (plane_q == PLANE_LAST);

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    plane_d   = plane_q;
    row_sel_d = row_sel_q;
    shreg_d   = shreg_q;
    bit_d     = bit_q;
    half_d    = half_q;
    sclk_d    = sclk_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE:  if (enable) state_d = S_FETCH;
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        shreg_d = rd_data;
        bit_d   = '0;
        half_d  = '0;
        sclk_d  = 1'b0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // Each sclk half lasts SCLK_HALF clks; data moves on the falling half boundary.
        if (half_q == HALF_LAST) begin
          half_d = '0;
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            shreg_d = {shreg_q[62:0], 1'b0};
            bit_d   = bit_q + 6'd1;
            if (bit_q == 6'd63) begin
              bit_d     = '0;
              row_sel_d = row_q;
              state_d   = S_LATCH;
            end
          end
        end else begin
          half_d = half_q + HW'(1);
        end
      end
      S_LATCH: begin
        cnt_d   = '0;
        state_d = S_DWELL;
      end
      S_DWELL: begin
        if (cnt_q == dwell_last) begin
          cnt_d   = '0;
          state_d = S_NEXT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_NEXT: begin
        plane_d = plane_wrap ? 3'd0 : plane_q + 3'd1;
        if (plane_wrap) row_d = (row_q == ROW_LAST) ? 4'd0 : row_q + 4'd1;
`ifdef ROW_BLANK_EN
        if (plane_wrap) begin
          cnt_d   = '0;
          state_d = S_BLANK;
        end else begin
          state_d = enable ? S_FETCH : S_IDLE;
        end
`else
        state_d = enable ? S_FETCH : S_IDLE;
`endif
      end
      S_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = enable ? S_FETCH : S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      plane_q   <= '0;
      row_sel_q <= '0;
      shreg_q   <= '0;
      bit_q     <= '0;
      half_q    <= '0;
      sclk_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      plane_q   <= plane_d;
      row_sel_q <= row_sel_d;
      shreg_q   <= shreg_d;
      bit_q     <= bit_d;
      half_q    <= half_d;
      sclk_q    <= sclk_d;
      cnt_q     <= cnt_d;
    end
  end

  assign rd_addr    = {row_q, plane_q};
  assign sdo        = (state_q == S_SHIFT) & shreg_q[63];
  assign sclk       = sclk_q;
  assign slatch     = (state_q == S_LATCH);
  assign oe_n       = (state_q != S_DWELL);
  assign row_sel    = row_sel_q;
  assign frame_sync = (state_q == S_NEXT) & plane_wrap & (row_q == ROW_LAST);

endmodule

// File: tb/tb_fb_scan_ctrl.sv
// Bench for fb_scan_ctrl: word table feeds a framebuffer model and a scoreboard checked at each latch.
// Build with ROW_BLANK_EN defined to expect the extra row-change blank gap.
module tb_fb_scan_ctrl;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [6:0]  rd_addr;
  logic [63:0] rd_data;
  logic        sdo;
  logic        sclk;
  logic        slatch;
  logic        oe_n;
  logic [3:0]  row_sel;
  logic        frame_sync;

  fb_scan_ctrl #(
    .ROWS(16), .PLANES(8), .SCLK_HALF(1), .DWELL_BASE(4), .BLANK_CYC(4)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .rd_addr(rd_addr), .rd_data(rd_data),
    .sdo(sdo), .sclk(sclk), .slatch(slatch), .oe_n(oe_n), .row_sel(row_sel),
    .frame_sync(frame_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  addr;
    logic [63:0] data;
    int          dwell;
    logic [3:0]  row;
  } vec_t;

  vec_t        tbl[128];
  vec_t        sb[$];
  logic [63:0] mem[128];

  int checks = 0;
  int errors = 0;
  int latch_cnt = 0;
  int dwell_done = 0;
  int frame_cnt = 0;
  int rise_cnt = 0;
  bit check_gap = 1'b0;

  // Framebuffer model: registered read, data valid one clk after the address.
  always @(posedge clk) rd_data <= mem[rd_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_latch(input int target, input int budget);
    int k;
    k = 0;
    while (latch_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("latch_reached", 64'(latch_cnt >= target), 64'd1);
  endtask

  // Monitor: rebuilds each shifted word, pops the scoreboard at slatch, times dwell and gaps.
  initial begin
    vec_t        r;
    logic [63:0] word_sh;
    logic        prev_sclk;
    logic        prev_oe;
    int          dwell_len;
    int          exp_dwell;
    int          gap_cnt;
    int          exp_gap;
    bit          gap_active;
    logic [6:0]  last_addr;
    word_sh = '0; prev_sclk = 1'b0; prev_oe = 1'b1; dwell_len = 0; exp_dwell = 0;
    gap_cnt = 0; exp_gap = 0; gap_active = 1'b0; last_addr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rise_cnt = 0; gap_active = 1'b0; dwell_len = 0; prev_sclk = 1'b0; prev_oe = 1'b1;
      end else begin
        if (sclk && !prev_sclk) begin
          word_sh = {word_sh[62:0], sdo};
          rise_cnt++;
          if (gap_active) begin
            if (check_gap) chk("row_gap", 64'(gap_cnt), 64'(exp_gap));
            gap_active = 1'b0;
          end
        end else if (gap_active) begin
          gap_cnt++;
        end
        if (slatch) begin
          latch_cnt++;
          chk("sb_level", 64'(sb.size() != 0), 64'd1);
          if (sb.size() != 0) begin
            r = sb.pop_front();
            chk("rd_addr", 64'(rd_addr), 64'(r.addr));
            chk("shift_word", word_sh, r.data);
            chk("sclk_rises", 64'(rise_cnt), 64'd64);
            chk("row_sel", 64'(row_sel), 64'(r.row));
            exp_dwell = r.dwell;
            last_addr = r.addr;
          end
          rise_cnt = 0;
        end
        if (!oe_n) dwell_len = prev_oe ? 1 : dwell_len + 1;
        if (oe_n && !prev_oe) begin
          chk("dwell_len", 64'(dwell_len), 64'(exp_dwell));
          dwell_done++;
          gap_active = 1'b1;
          gap_cnt = 1;
`ifdef ROW_BLANK_EN
          exp_gap = (last_addr[2:0] == 3'd7) ? 8 : 4;
`else
          exp_gap = 4;
`endif
        end
        if (frame_sync) begin
          frame_cnt++;
          chk("fsync_word", 64'(last_addr), 64'd127);
          chk("fsync_after_dwell", 64'(prev_oe), 64'd0);
        end
        prev_sclk = sclk;
        prev_oe = oe_n;
      end
    end
  end

  initial begin
    int n;
    int act;
    for (int i = 0; i < 128; i++) begin
      tbl[i].addr  = 7'(i);
      tbl[i].data  = (i == 0) ? 64'h8000_0000_0000_0001 : {$urandom, $urandom};
      tbl[i].dwell = 4 << (i % 8);
      tbl[i].row   = 4'(i / 8);
      mem[i]       = tbl[i].data;
    end

    reset = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_oe_n", 64'(oe_n), 64'd1);
    chk("rst_sclk", 64'(sclk), 64'd0);
    chk("rst_sdo", 64'(sdo), 64'd0);
    chk("rst_slatch", 64'(slatch), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_row_sel", 64'(row_sel), 64'd0);
    chk("rst_frame_sync", 64'(frame_sync), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Full frame plus the first word of the following frame.
    for (int i = 0; i < 128; i++) sb.push_back(tbl[i]);
    sb.push_back(tbl[0]);
    check_gap = 1'b1;
    enable = 1'b1;
    n = 0;
    while (oe_n && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("latency_to_oe", 64'(n), 64'd132);
    wait_latch(129, 60000);
    chk("frame_sync_count", 64'(frame_cnt), 64'd1);

    // Drop enable mid-shift: word 1 must finish, then the scan parks.
    sb.push_back(tbl[1]);
    sb.push_back(tbl[2]);
    n = 0;
    while (!(latch_cnt == 129 && rise_cnt >= 5) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_gap = 1'b0;
    enable = 1'b0;
    wait_latch(130, 2000);
    n = 0;
    while (dwell_done < 130 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("dwell_after_drop", 64'(dwell_done >= 130), 64'd1);
    repeat (2) @(negedge clk);
    act = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sclk || !oe_n || slatch) act++;
    end
    chk("idle_quiet", 64'(act), 64'd0);
    chk("idle_rd_addr", 64'(rd_addr), 64'd2);
    enable = 1'b1;
    wait_latch(131, 2000);
    check_gap = 1'b1;

    // Run into row 1, then reset in the middle of a dwell.
    for (int i = 3; i < 10; i++) sb.push_back(tbl[i]);
    wait_latch(138, 10000);
    n = 0;
    while (oe_n && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("dwell_seen", 64'(oe_n), 64'd0);
    chk("row_sel_before_rst", 64'(row_sel), 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    enable = 1'b0;
    check_gap = 1'b0;
    @(negedge clk);
    chk("midrst_oe_n", 64'(oe_n), 64'd1);
    chk("midrst_sclk", 64'(sclk), 64'd0);
    chk("midrst_row_sel", 64'(row_sel), 64'd0);
    chk("midrst_rd_addr", 64'(rd_addr), 64'd0);
    chk("midrst_slatch", 64'(slatch), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    sb.push_back(tbl[0]);
    enable = 1'b1;
    wait_latch(139, 2000);
    enable = 1'b0;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
